// File: rtl/apb2tmu_mc.sv
// APB slave bridging to NUM_CH TMU channels: registered output words with write
// strobes, per-channel input FIFOs popped by reads, sticky error flags and an irq.
module apb2tmu_mc #(
  parameter int NUM_CH     = 2,
  parameter int DW         = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [31:0]          PADDR,
  input  logic [31:0]          PWDATA,
  output logic [31:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  input  logic [NUM_CH*DW-1:0] data_in,
  input  logic [NUM_CH-1:0]    data_in_valid,
  output logic [NUM_CH*DW-1:0] data_out,
  output logic [NUM_CH-1:0]    wr_en,
  output logic                 irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DW-1:0]     mem  [NUM_CH][FIFO_DEPTH];
  logic [AW:0]       wptr [NUM_CH];
  logic [AW:0]       rptr [NUM_CH];
  logic [DW-1:0]     dout [NUM_CH];
  logic [NUM_CH-1:0] ovf, udf, irq_en;

  logic [9:0]        idx;
  logic [3:0]        ch;
  logic              access, ch_ok, mapped, rd_acc, wr_acc;
  logic              hit_out, hit_in, hit_stat, hit_clr, hit_ien;
  logic [NUM_CH-1:0] sel_ch, empty, full, pop, push;
  logic [NUM_CH-1:0] ovf_set, udf_set, ovf_clr, udf_clr;
  logic [AW:0]       cnt0;
  logic [4:0]        cnt0_ext;
  logic [31:0]       stat;
  logic              unused;

  assign PREADY = 1'b1;
  assign unused = ^{PADDR[31:12], PADDR[1:0], PWDATA};

  always_comb begin
    idx    = PADDR[11:2];
    ch     = idx[3:0];
    access = PSEL & PENABLE;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      sel_ch[n] = (ch == n[3:0]);
      empty[n]  = (wptr[n] == rptr[n]);
      full[n]   = (wptr[n][AW] != rptr[n][AW]) && (wptr[n][AW-1:0] == rptr[n][AW-1:0]);
    end
    // channel indices at or above NUM_CH match no sel_ch bit and stay unmapped
    ch_ok    = |sel_ch;
    hit_out  = (idx[9:4] == 6'h00) && ch_ok;
    hit_in   = (idx[9:4] == 6'h01) && ch_ok;
    hit_stat = (idx == 10'h020);
    hit_clr  = (idx == 10'h021);
    hit_ien  = (idx == 10'h022);
    mapped   = PWRITE ? (hit_out | hit_clr | hit_ien)
                      : (hit_out | hit_in | hit_stat | hit_ien);
    PSLVERR  = access & ~mapped;
    rd_acc   = access & ~PWRITE & mapped;
    wr_acc   = access &  PWRITE & mapped;
  end

  always_comb begin
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      pop[n]     = rd_acc & hit_in & sel_ch[n] & ~empty[n];
      udf_set[n] = rd_acc & hit_in & sel_ch[n] &  empty[n];
      // a full FIFO still accepts a push when the same cycle pops it
      push[n]    = data_in_valid[n] & (~full[n] | pop[n]);
      ovf_set[n] = data_in_valid[n] &  full[n] & ~pop[n];
    end
    ovf_clr = (wr_acc & hit_clr) ? PWDATA[8  +: NUM_CH] : '0;
    udf_clr = (wr_acc & hit_clr) ? PWDATA[16 +: NUM_CH] : '0;
  end

  always_comb begin
    cnt0     = wptr[0] - rptr[0];
    cnt0_ext = 5'(cnt0);
    stat     = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      stat[n]      = ~empty[n];
      stat[8 + n]  = ovf[n];
      stat[16 + n] = udf[n];
    end
    stat[27:24] = cnt0_ext[3:0];
  end

  always_comb begin
    PRDATA = '0;
    if (rd_acc) begin
      if (hit_stat) PRDATA = stat;
      if (hit_ien)  PRDATA[NUM_CH-1:0] = irq_en;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        if (hit_out && sel_ch[n]) PRDATA[DW-1:0] = dout[n];
        if (hit_in && sel_ch[n] && !empty[n]) PRDATA[DW-1:0] = mem[n][rptr[n][AW-1:0]];
      end
    end
  end

  always_comb begin
    data_out = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) data_out[n*DW +: DW] = dout[n];
  end

  always_ff @(posedge PCLK) begin
    for (int unsigned n = 0; n < NUM_CH; n++)
      if (PRESETn && push[n]) mem[n][wptr[n][AW-1:0]] <= data_in[n*DW +: DW];
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        dout[n] <= '0;
        wptr[n] <= '0;
        rptr[n] <= '0;
      end
      wr_en  <= '0;
      ovf    <= '0;
      udf    <= '0;
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      wr_en <= '0;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        if (wr_acc && hit_out && sel_ch[n]) begin
          dout[n]  <= PWDATA[DW-1:0];
          wr_en[n] <= 1'b1;
        end
        if (push[n]) wptr[n] <= wptr[n] + (AW+1)'(1);
        if (pop[n])  rptr[n] <= rptr[n] + (AW+1)'(1);
      end
      ovf <= (ovf & ~ovf_clr) | ovf_set;
      udf <= (udf & ~udf_clr) | udf_set;
      if (wr_acc && hit_ien) irq_en <= PWDATA[NUM_CH-1:0];
      irq <= |(~empty & irq_en);
    end
  end

endmodule

// File: tb/tb_apb2tmu_mc.sv
// Bench for apb2tmu_mc: directed scenarios plus random traffic, every cycle checked
// against a queue-based model of the register map and FIFOs.
module tb_apb2tmu_mc;
  localparam int NUM_CH = 2;
  localparam int DW     = 12;
  localparam int DEPTH  = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, irq;
  logic [23:0] data_in, data_out;
  logic [1:0]  data_in_valid, wr_en;

  int n_chk  = 0;
  int n_fail = 0;

  int          q [NUM_CH][$];
  logic [11:0] m_dout [NUM_CH];
  logic [1:0]  m_wren, m_ovf, m_udf, m_ien;
  logic        m_irq;

  apb2tmu_mc #(.NUM_CH(NUM_CH), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_out(data_out),
    .wr_en(wr_en), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      s[n]      = (q[n].size() > 0);
      s[8 + n]  = m_ovf[n];
      s[16 + n] = m_udf[n];
    end
    s[27:24] = 4'(q[0].size());
    return s;
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      q[n].delete();
      m_dout[n] = '0;
    end
    m_wren = '0; m_ovf = '0; m_udf = '0; m_ien = '0; m_irq = 1'b0;
  endfunction

  function automatic void exp_comb(input bit sel, input bit en, input bit wr,
                                   input logic [31:0] addr,
                                   output logic [31:0] prd, output logic err);
    int idx;
    bit is_out, is_in;
    idx    = int'(addr[11:2]);
    is_out = idx < NUM_CH;
    is_in  = idx >= 16 && idx < 16 + NUM_CH;
    prd    = '0;
    err    = 1'b0;
    if (sel && en) begin
      if (wr) err = !(is_out || idx == 33 || idx == 34);
      else begin
        err = !(is_out || is_in || idx == 32 || idx == 34);
        if (is_out)          prd = 32'(m_dout[idx]);
        else if (is_in)      prd = (q[idx-16].size() > 0) ? 32'(q[idx-16][0]) : 32'd0;
        else if (idx == 32)  prd = m_status();
        else if (idx == 34)  prd = 32'(m_ien);
      end
    end
  endfunction

  function automatic void model_step(input bit rstn, input bit sel, input bit en, input bit wr,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [1:0] vld, input logic [11:0] d0,
                                     input logic [11:0] d1);
    int idx;
    bit acc, irq_n;
    if (!rstn) begin
      model_reset();
      return;
    end
    idx   = int'(addr[11:2]);
    acc   = sel && en;
    irq_n = 1'b0;
    for (int n = 0; n < NUM_CH; n++) if (q[n].size() > 0 && m_ien[n]) irq_n = 1'b1;
    m_wren = '0;
    if (acc && wr) begin
      if (idx < NUM_CH) begin
        m_dout[idx] = wdata[11:0];
        m_wren[idx] = 1'b1;
      end else if (idx == 33) begin
        m_ovf = m_ovf & ~wdata[9:8];
        m_udf = m_udf & ~wdata[17:16];
      end else if (idx == 34) m_ien = wdata[1:0];
    end
    if (acc && !wr && idx >= 16 && idx < 16 + NUM_CH) begin
      if (q[idx-16].size() > 0) void'(q[idx-16].pop_front());
      else m_udf[idx-16] = 1'b1;
    end
    for (int n = 0; n < NUM_CH; n++)
      if (vld[n]) begin
        if (q[n].size() < DEPTH) q[n].push_back(int'(n == 0 ? d0 : d1));
        else m_ovf[n] = 1'b1;
      end
    m_irq = irq_n;
  endfunction

  task automatic tick(input bit rstn, input bit sel, input bit en, input bit wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] vld, input logic [11:0] d0, input logic [11:0] d1,
                      output logic [31:0] rd);
    logic [31:0] eprd;
    logic        eerr;
    PRESETn = rstn; PSEL = sel; PENABLE = en; PWRITE = wr;
    PADDR = addr; PWDATA = wdata; data_in_valid = vld; data_in = {d1, d0};
    #1;
    exp_comb(sel, en, wr, addr, eprd, eerr);
    chk("PRDATA",   PRDATA, eprd);
    chk("PSLVERR",  {31'b0, PSLVERR}, {31'b0, eerr});
    chk("PREADY",   {31'b0, PREADY}, 32'd1);
    chk("data_out", {8'b0, data_out}, {8'b0, m_dout[1], m_dout[0]});
    chk("wr_en",    {30'b0, wr_en}, {30'b0, m_wren});
    chk("irq",      {31'b0, irq}, {31'b0, m_irq});
    rd = PRDATA;
    @(posedge PCLK);
    model_step(rstn, sel, en, wr, addr, wdata, vld, d0, d1);
    #1;
  endtask

  task automatic idle(input logic [1:0] vld, input logic [11:0] d0, input logic [11:0] d1);
    logic [31:0] r;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, vld, d0, d1, r);
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r;
    tick(1'b1, 1'b1, 1'b0, 1'b1, addr, data, 2'b00, 12'h0, 12'h0, r);
    tick(1'b1, 1'b1, 1'b1, 1'b1, addr, data, 2'b00, 12'h0, 12'h0, r);
  endtask

  task automatic apb_rd(input logic [31:0] addr, input logic [1:0] vld,
                        input logic [11:0] d0, input logic [11:0] d1, output logic [31:0] rd);
    logic [31:0] r;
    tick(1'b1, 1'b1, 1'b0, 1'b0, addr, 32'h0, 2'b00, 12'h0, 12'h0, r);
    tick(1'b1, 1'b1, 1'b1, 1'b0, addr, 32'h0, vld, d0, d1, rd);
  endtask

  initial begin
    logic [31:0] rd;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; data_in = '0; data_in_valid = '0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    model_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 12'h0, 12'h0, rd);
    apb_rd(32'h080, 2'b00, 12'h0, 12'h0, rd);
    chk("reset_status", rd, 32'h0);

    // CH_OUT[1] write with upper data bits that must be dropped
    apb_wr(32'h004, 32'h00FF_FABC);
    idle(2'b00, 12'h0, 12'h0);
    idle(2'b00, 12'h0, 12'h0);
    apb_rd(32'h004, 2'b00, 12'h0, 12'h0, rd);
    chk("ch_out1_rd", rd, 32'h0000_0ABC);

    // overflow channel 0 then drain past empty
    for (int i = 1; i <= 5; i++) idle(2'b01, 12'(i), 12'h0);
    apb_rd(32'h080, 2'b00, 12'h0, 12'h0, rd);
    chk("status_ovf", rd, 32'h0400_0101);
    for (int i = 1; i <= 4; i++) begin
      apb_rd(32'h040, 2'b00, 12'h0, 12'h0, rd);
      chk("ch_in0_pop", rd, 32'(i));
    end
    apb_rd(32'h040, 2'b00, 12'h0, 12'h0, rd);
    chk("ch_in0_udf", rd, 32'h0);
    apb_rd(32'h080, 2'b00, 12'h0, 12'h0, rd);
    chk("status_udf", rd, 32'h0001_0100);
    apb_wr(32'h084, 32'h0001_0100);
    apb_rd(32'h080, 2'b00, 12'h0, 12'h0, rd);
    chk("status_clr", rd, 32'h0);

    // full channel 1 with push and pop together
    for (int i = 0; i < 4; i++) idle(2'b10, 12'h0, 12'(10 + i));
    apb_rd(32'h044, 2'b10, 12'h0, 12'd14, rd);
    chk("ch_in1_head", rd, 32'd10);
    apb_rd(32'h080, 2'b00, 12'h0, 12'h0, rd);
    chk("status_noovf", rd, 32'h0000_0002);
    for (int i = 11; i <= 14; i++) begin
      apb_rd(32'h044, 2'b00, 12'h0, 12'h0, rd);
      chk("ch_in1_order", rd, 32'(i));
    end

    // irq timing
    apb_wr(32'h088, 32'h1);
    idle(2'b01, 12'd7, 12'h0);
    idle(2'b00, 12'h0, 12'h0);
    chk("irq_on", {31'b0, irq}, 32'd1);
    apb_rd(32'h040, 2'b00, 12'h0, 12'h0, rd);
    chk("irq_pop", rd, 32'd7);
    idle(2'b00, 12'h0, 12'h0);
    chk("irq_off", {31'b0, irq}, 32'd0);

    // unmapped accesses and selective flag clear
    apb_rd(32'h014, 2'b00, 12'h0, 12'h0, rd);
    chk("unmapped_rd", rd, 32'h0);
    apb_wr(32'h080, 32'hFFFF_FFFF);
    apb_rd(32'h084, 2'b00, 12'h0, 12'h0, rd);
    for (int i = 0; i < 5; i++) idle(2'b01, 12'(20 + i), 12'h0);
    apb_wr(32'h084, 32'h0000_0100);
    apb_rd(32'h080, 2'b00, 12'h0, 12'h0, rd);
    chk("ovf0_cleared", rd, 32'h0400_0001);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, w, r;
      logic [9:0]  ix;
      int          pick;
      pick = $urandom_range(0, 11);
      case (pick)
        0: ix = 10'h000;  1: ix = 10'h001;  2: ix = 10'h002;  3: ix = 10'h010;
        4: ix = 10'h011;  5: ix = 10'h012;  6: ix = 10'h020;  7: ix = 10'h021;
        8: ix = 10'h022;  9: ix = 10'h023; 10: ix = 10'h005;
        default: ix = 10'($urandom_range(0, 1023));
      endcase
      a = $urandom();
      a[11:2] = ix;
      w = $urandom();
      tick($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), a, w, 2'($urandom_range(0, 3)),
           12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), r);
    end

    // reset in the middle of a read burst with data buffered
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 12'h0, 12'h0, rd);
    apb_wr(32'h088, 32'h3);
    apb_wr(32'h000, 32'h123);
    for (int i = 0; i < 3; i++) idle(2'b11, 12'(30 + i), 12'(40 + i));
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h040, 32'h0, 2'b11, 12'd50, 12'd60, rd);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h040, 32'h0, 2'b11, 12'd51, 12'd61, rd);
    idle(2'b00, 12'h0, 12'h0);
    chk("rst_data_out", {8'b0, data_out}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    apb_rd(32'h080, 2'b00, 12'h0, 12'h0, rd);
    chk("rst_status", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
